div_unit: RTL and testbench

Iterative radix-2 integer divider for the LoongArch execute stage. It implements div.w, div.wu, mod.w and mod.wu and returns quotient and remainder together. It accepts one operation at a time through a valid/ready handshake, takes 33 cycles per non-trivial operation, and holds its result until the pipeline consumes it. Its outputs feed the execute-stage result select alongside the ALU adder.

---
 rtl/div_unit_if.sv | 43 ++++
 rtl/div_unit.sv | 120 ++++++++++++
 tb/tb_div_unit.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// -----------------------------------------------------------------------------
// div_unit_if
//   Request / result bundle between the execute stage and the iterative
//   divider.
//
//   Signals (WIDTH-bit operands/results):
//     flush       pipeline flush, cancels any operation in flight
//     div_valid   operation request
//     div_ready   divider can accept a request
//     div_signed  1 = signed (div.w/mod.w), 0 = unsigned (div.wu/mod.wu)
//     dividend    numerator, captured on acceptance
//     divisor     denominator, captured on acceptance
//     res_valid   quotient/remainder valid
//     res_ready   consumer takes the result
//     quotient    registered quotient
//     remainder   registered remainder
//
//   Modports: master = execute stage (requester), slave = divider.
// -----------------------------------------------------------------------------
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             flush;
  logic             div_valid;
  logic             div_ready;
  logic             div_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output flush, div_valid, div_signed, dividend, divisor, res_ready,
    input  div_ready, res_valid, quotient, remainder
  );

  modport slave (
    input  flush, div_valid, div_signed, dividend, divisor, res_ready,
    output div_ready, res_valid, quotient, remainder
  );
endinterface

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
//   Iterative radix-2 restoring divider for div.w / div.wu / mod.w / mod.wu.
//   Works on operand magnitudes and applies the result signs on the final
//   step, so the remainder takes the sign of the dividend (truncating
//   division). One request at a time; 32 iteration cycles after acceptance,
//   then the result is held until the consumer takes it.
//
//   Ports:
//     clk     rising-edge clock
//     resetn  synchronous active-low reset
//     bus     div_unit_if.slave: request handshake, operands, result handshake,
//             quotient/remainder, flush
// -----------------------------------------------------------------------------
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       resetn,
  div_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] prem;        // partial remainder
  logic [WIDTH-1:0] dmag;        // dividend magnitude, quotient bits shift in
  logic [WIDTH-1:0] smag;        // divisor magnitude
  logic             q_neg;
  logic             r_neg;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             fits;
  logic [WIDTH-1:0] prem_nxt;
  logic [WIDTH-1:0] dmag_nxt;

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v,
                                               input logic             sgn);
    return (sgn && v[WIDTH-1]) ? (~v + ONE) : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                input logic             neg);
    return neg ? (~v + ONE) : v;
  endfunction

  // Iteration step: partial remainder is always below the divisor magnitude,
  // so the shifted value fits WIDTH+1 bits and the MSB of the WIDTH+1-bit
  // difference is a reliable borrow flag.
  assign shifted  = {prem, dmag[WIDTH-1]};
  assign diff     = shifted - {1'b0, smag};
  assign fits     = ~diff[WIDTH];
  assign prem_nxt = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign dmag_nxt = {dmag[WIDTH-2:0], fits};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      cnt         <= '0;
      quotient_r  <= '0;
      remainder_r <= '0;
    end else if (bus.flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.div_valid) begin
            dmag  <= abs_val(bus.dividend, bus.div_signed);
            smag  <= abs_val(bus.divisor, bus.div_signed);
            q_neg <= bus.div_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
            r_neg <= bus.div_signed & bus.dividend[WIDTH-1];
            cnt   <= '0;
            prem  <= '0;
            if (bus.divisor == '0) begin
              // Divide by zero: architectural result, no iteration.
              quotient_r  <= '1;
              remainder_r <= bus.dividend;
              state       <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          prem <= prem_nxt;
          dmag <= dmag_nxt;
          cnt  <= cnt + CNT_ONE;
          if (cnt == CNT_LAST) begin
            quotient_r  <= cond_neg(dmag_nxt, q_neg);
            remainder_r <= cond_neg(prem_nxt, r_neg);
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.div_ready = (state == IDLE);
  assign bus.res_valid = (state == DONE);
  assign bus.quotient  = quotient_r;
  assign bus.remainder = remainder_r;

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit
//   Self-checking bench for div_unit: directed cases from the divider's
//   behaviour (sign cases, overflow, divide by zero, backpressure, flush,
//   reset) followed by randomized operations checked against a plain
//   arithmetic reference.
// -----------------------------------------------------------------------------
module tb_div_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  div_unit_if #(.WIDTH(W)) bus ();

  div_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: truncating division semantics of the LoongArch ops.
  function automatic void ref_div(input logic sgn, input logic [W-1:0] a,
                                  input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = '0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // All tasks are entered and left 1 time unit after a rising edge.
  task automatic start_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = 0;
    while (!bus.div_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_ready", W'(bus.div_ready), W'(1));
    bus.div_signed = sgn;
    bus.dividend   = a;
    bus.divisor    = b;
    bus.div_valid  = 1'b1;
    @(posedge clk); #1;
    bus.div_valid  = 1'b0;
    bus.dividend   = $urandom;
    bus.divisor    = $urandom;
    bus.div_signed = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_res(output int lat);
    logic busy_rdy;
    busy_rdy = 1'b0;
    lat = 0;
    while (!bus.res_valid && lat < 200) begin
      if (bus.div_ready) busy_rdy = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk("busy_ready", W'(busy_rdy), W'(0));
  endtask

  task automatic consume();
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    chk("consume_res_valid", W'(bus.res_valid), W'(0));
    chk("consume_div_ready", W'(bus.div_ready), W'(1));
  endtask

  task automatic run_op(input string tag, input logic sgn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eq,
                        input logic [W-1:0] er);
    int lat;
    int elat;
    start_op(sgn, a, b);
    wait_res(lat);
    elat = (b == '0) ? 0 : 32;
    chk({tag, "_lat"}, W'(lat), W'(elat));
    chk({tag, "_q"}, bus.quotient, eq);
    chk({tag, "_r"}, bus.remainder, er);
    consume();
  endtask

  initial begin
    logic [W-1:0] a, b, eq, er;
    logic         sgn;
    logic         rv_seen;
    int           lat;

    bus.flush      = 1'b0;
    bus.div_valid  = 1'b0;
    bus.div_signed = 1'b0;
    bus.dividend   = '0;
    bus.divisor    = '0;
    bus.res_ready  = 1'b0;
    resetn         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;

    chk("rst_div_ready", W'(bus.div_ready), W'(1));
    chk("rst_res_valid", W'(bus.res_valid), W'(0));
    chk("rst_quotient", bus.quotient, '0);
    chk("rst_remainder", bus.remainder, '0);

    run_op("u_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    run_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_op("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    run_op("s_m7_m2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF);
    run_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    run_op("u_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_op("u_div0", 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678);
    run_op("s_div0", 1'b1, 32'h8765_4321, 32'd0, 32'hFFFF_FFFF, 32'h8765_4321);

    // Backpressure, with a request presented while the result is held.
    start_op(1'b0, 32'd1000, 32'd33);
    wait_res(lat);
    chk("bp_lat", W'(lat), W'(32));
    chk("bp_q", bus.quotient, 32'd30);
    chk("bp_r", bus.remainder, 32'd10);
    bus.div_valid = 1'b1;
    bus.dividend  = 32'd5;
    bus.divisor   = 32'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_q", bus.quotient, 32'd30);
      chk("bp_hold_r", bus.remainder, 32'd10);
      chk("bp_hold_res_valid", W'(bus.res_valid), W'(1));
      chk("bp_hold_div_ready", W'(bus.div_ready), W'(0));
    end
    bus.div_valid = 1'b0;
    consume();
    run_op("u_50_5", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0);

    // Flush on CALC step 10.
    start_op(1'b0, 32'hDEAD_BEEF, 32'd3);
    repeat (10) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush_div_ready", W'(bus.div_ready), W'(1));
    chk("flush_res_valid", W'(bus.res_valid), W'(0));
    chk("flush_q_kept", bus.quotient, 32'd10);
    rv_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.res_valid) rv_seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("flush_no_result", W'(rv_seen), W'(0));
    run_op("u_ff_16", 1'b0, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 32'd15);

    // Reset during CALC.
    start_op(1'b1, 32'd1000, 32'd7);
    repeat (5) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    chk("mid_rst_div_ready", W'(bus.div_ready), W'(1));
    chk("mid_rst_res_valid", W'(bus.res_valid), W'(0));
    chk("mid_rst_quotient", bus.quotient, '0);
    chk("mid_rst_remainder", bus.remainder, '0);
    run_op("u_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);

    // Randomized operations against the reference.
    for (int i = 0; i < 24; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      case ($urandom_range(0, 2))
        0:       b = $urandom;
        1:       b = W'($urandom_range(1, 255));
        default: b = -W'($urandom_range(1, 100));
      endcase
      if (i % 8 == 7) b = '0;
      if (i % 5 == 3) a = W'($urandom_range(0, 50));
      ref_div(sgn, a, b, eq, er);
      run_op("rnd", sgn, a, b, eq, er);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
